fp_mul_arbiter: RTL

Controller that shares a single FP32 multiplier datapath between two requesters. It arbitrates round-robin, registers the winning operands and rounding mode, and holds them on the multiplier inputs for a fixed latency. It then captures product and exception flags and returns them on the winner's response channel. It sits between the issue logic and the shared multiplier; one operation is in flight at a time.

---
 rtl/fp_mul_arb_pkg.sv | 29 ++
 rtl/fp_mul_rr_arb.sv | 28 ++
 rtl/fp_mul_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fp_mul_arb_pkg.sv
// Shared definitions for the FP32 multiplier arbiter: FSM states,
// FP32 field positions and the latency counter width.
package fp_mul_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int         EXP_MSB  = 30;
    localparam int         EXP_LSB  = 23;
    localparam int         SIGN_BIT = 31;
    localparam logic [7:0] EXP_INF  = 8'hFF;

    // MUL_LAT tops out at 15, so the countdown never needs more than 4 bits
    localparam int CNT_W = 4;

    // Zero or subnormal on either side gives a signed zero, unless an
    // Inf/NaN is involved, in which case the real multiplier must decide.
    function automatic logic is_zero_bypass(input logic [31:0] x, input logic [31:0] y);
        logic [7:0] ex;
        logic [7:0] ey;
        ex = x[EXP_MSB:EXP_LSB];
        ey = y[EXP_MSB:EXP_LSB];
        return ((ex == 8'd0) || (ey == 8'd0)) && (ex != EXP_INF) && (ey != EXP_INF);
    endfunction

endpackage

// File: rtl/fp_mul_rr_arb.sv
// Two-way round-robin grant. The pointer names the preferred requester
// and flips only when the arbiter owner finishes its response.
module fp_mul_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    input  logic       advance,
    output logic       grant,
    output logic       grant_vld
);

    logic ptr;

    // Priority pointer, moves to the other requester on completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= 1'b0;
        else if (advance)
            ptr <= ~ptr;
    end

    // Preferred requester wins if asking, otherwise the other one
    always_comb begin
        grant     = req_valid[ptr] ? ptr : ~ptr;
        grant_vld = |req_valid;
    end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one external FP32 multiplier between two requesters.
// One operation in flight: IDLE accepts, BUSY waits MUL_LAT cycles,
// RESP returns the product to the owner.
// Optional build macro: FP_MUL_ARB_ZERO_BYPASS_EN answers zero/subnormal
// operand pairs directly without launching the multiplier.
module fp_mul_arbiter
    import fp_mul_arb_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0][31:0] req_X,
    input  logic [1:0][31:0] req_Y,
    input  logic [1:0][2:0]  req_rmode,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [31:0]      rsp_Z,
    output logic             rsp_ovrf,
    output logic             rsp_udrf,
    output logic [31:0]      mul_X,
    output logic [31:0]      mul_Y,
    output logic [2:0]       mul_rmode,
    input  logic [31:0]      mul_Z,
    input  logic             mul_ovrf,
    input  logic             mul_udrf
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             owner;
    logic             grant;
    logic             grant_vld;
    logic             accept;
    logic             advance;
    logic             bypass;

    fp_mul_rr_arb u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .advance   (advance),
        .grant     (grant),
        .grant_vld (grant_vld)
    );

    assign accept  = (state == IDLE) && grant_vld;
    assign advance = (state == RESP) && rsp_ready[owner];

`ifdef FP_MUL_ARB_ZERO_BYPASS_EN
    assign bypass = is_zero_bypass(req_X[grant], req_Y[grant]);
`else
    assign bypass = 1'b0;
`endif

    // Handshake strobes: ready only to the winner in IDLE, valid only to the owner in RESP
    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        if (rst_n && accept)
            req_ready[grant] = 1'b1;
        if (state == RESP)
            rsp_valid[owner] = 1'b1;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = bypass ? RESP : BUSY;
            BUSY:    if (cnt == '0) state_nxt = RESP;
            RESP:    if (advance) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Latency countdown and owner tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            owner <= 1'b0;
        end else if (accept) begin
            cnt   <= CNT_W'(MUL_LAT - 1);
            owner <= grant;
        end else if ((state == BUSY) && (cnt != '0)) begin
            cnt   <= cnt - CNT_W'(1);
        end
    end

    // Operand launch registers, held until the next multiplier launch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_X     <= '0;
            mul_Y     <= '0;
            mul_rmode <= '0;
        end else if (accept && !bypass) begin
            mul_X     <= req_X[grant];
            mul_Y     <= req_Y[grant];
            mul_rmode <= req_rmode[grant];
        end
    end

    // Response capture: bypassed signed zero at accept, or multiplier output at end of BUSY
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_Z    <= '0;
            rsp_ovrf <= 1'b0;
            rsp_udrf <= 1'b0;
        end else if (accept && bypass) begin
            rsp_Z    <= {req_X[grant][SIGN_BIT] ^ req_Y[grant][SIGN_BIT], 31'b0};
            rsp_ovrf <= 1'b0;
            rsp_udrf <= 1'b0;
        end else if ((state == BUSY) && (cnt == '0)) begin
            rsp_Z    <= mul_Z;
            rsp_ovrf <= mul_ovrf;
            rsp_udrf <= mul_udrf;
        end
    end

endmodule
